// File: rtl/rcc_sys_clk_switch_ctrl.sv
// System clock source switch sequencer: waits for the target oscillator to be ready,
// gates sys_clk, moves the one-hot mux select while gated, then ungates.
module rcc_sys_clk_switch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned GATE_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic [3:0] src_rdy,
  input  logic       hsecss_fail,
  input  logic       stop_entry,
  input  logic       stopwuck,
  input  logic       err_clr,
  output logic [1:0] sws,
  output logic [3:0] sel_onehot,
  output logic       clk_gate_en,
  output logic       sw_busy,
  output logic       sw_err
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_W = $clog2(GATE_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [1:0] SRC_HSI = 2'd0;
  localparam logic [1:0] SRC_CSI = 2'd1;
  localparam logic [1:0] SRC_HSE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_DESEL    = 2'd2,
    ST_SEL      = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_tgt;
  logic [1:0]       w_tgt_nxt;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_sws;
  logic [1:0]       w_sws_nxt;
  logic [3:0]       r_sel;
  logic [3:0]       w_sel_nxt;
  logic             r_gate;
  logic             w_gate_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_err_set;
  logic [1:0]       w_target;

  // Requested source as seen from IDLE; forced targets bypass the sticky error
  always_comb begin
    w_target = r_sws;
    if (stop_entry) begin
      w_target = stopwuck ? SRC_CSI : SRC_HSI;
    end else if (hsecss_fail && (r_sws == SRC_HSE)) begin
      w_target = SRC_HSI;
    end else if (!r_err) begin
      w_target = sw;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_tmo_nxt   = r_tmo;
    w_cnt_nxt   = r_cnt;
    w_sws_nxt   = r_sws;
    w_sel_nxt   = r_sel;
    w_gate_nxt  = r_gate;
    w_busy_nxt  = r_busy;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_target != r_sws) begin
          w_state_nxt = ST_WAIT_RDY;
          w_tgt_nxt   = w_target;
          w_busy_nxt  = 1'b1;
          w_tmo_nxt   = '0;
        end
      end
      ST_WAIT_RDY: begin
        if ((r_tgt == SRC_HSE) && hsecss_fail) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_err_set   = 1'b1;
        end else if (src_rdy[r_tgt]) begin
          w_state_nxt = ST_DESEL;
          w_gate_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_err_set   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      ST_DESEL: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_SEL;
          w_sel_nxt   = 4'b0001 << r_tgt;
          w_sws_nxt   = r_tgt;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_SEL: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_gate_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Error set has priority over a same-cycle clear
    w_err_nxt = w_err_set ? 1'b1 : (err_clr ? 1'b0 : r_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tgt   <= SRC_HSI;
      r_tmo   <= '0;
      r_cnt   <= '0;
      r_sws   <= SRC_HSI;
      r_sel   <= 4'b0001;
      r_gate  <= 1'b1;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sws   <= w_sws_nxt;
      r_sel   <= w_sel_nxt;
      r_gate  <= w_gate_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign sws         = r_sws;
  assign sel_onehot  = r_sel;
  assign clk_gate_en = r_gate;
  assign sw_busy     = r_busy;
  assign sw_err      = r_err;

endmodule

// File: tb/tb_rcc_sys_clk_switch_ctrl.sv
// Bench for rcc_sys_clk_switch_ctrl: directed scenarios then random traffic, all outputs
// compared every cycle against a timestamp-based reference model.
module tb_rcc_sys_clk_switch_ctrl;

  localparam int TMO = 16;
  localparam int G   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] t_sw;
  logic [3:0] t_rdy;
  logic       t_css;
  logic       t_stop;
  logic       t_wuck;
  logic       t_clr;
  logic [1:0] d_sws;
  logic [3:0] d_sel;
  logic       d_gate;
  logic       d_busy;
  logic       d_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a switch is a start edge, an optional ready edge, and fixed offsets from it
  int   cyc = 0;
  int   m_sws, m_tgt, m_wait_start, m_rdy_at;
  bit   m_gate, m_busy, m_err, m_active, m_rst_edge;
  logic [3:0] p_sel;

  rcc_sys_clk_switch_ctrl #(.TIMEOUT_CYCLES(TMO), .GATE_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .sw(t_sw), .src_rdy(t_rdy), .hsecss_fail(t_css),
    .stop_entry(t_stop), .stopwuck(t_wuck), .err_clr(t_clr),
    .sws(d_sws), .sel_onehot(d_sel), .clk_gate_en(d_gate), .sw_busy(d_busy), .sw_err(d_err)
  );

  always #5 clk = ~clk;

  function automatic int m_target();
    if (t_stop) return t_wuck ? 1 : 0;
    if (t_css && m_sws == 2) return 0;
    if (!m_err) return int'(t_sw);
    return m_sws;
  endfunction

  task automatic model_edge();
    bit err_set = 1'b0;
    int t;
    cyc++;
    m_rst_edge = rst;
    if (rst) begin
      m_sws = 0; m_gate = 1; m_busy = 0; m_err = 0; m_active = 0;
    end else begin
      if (!m_active) begin
        t = m_target();
        if (t != m_sws) begin
          m_active = 1; m_tgt = t; m_wait_start = cyc; m_rdy_at = -1; m_busy = 1;
        end
      end else if (m_rdy_at < 0) begin
        if (m_tgt == 2 && t_css) begin
          m_active = 0; m_busy = 0; err_set = 1;
        end else if (t_rdy[m_tgt]) begin
          m_rdy_at = cyc; m_gate = 0;
        end else if (cyc - m_wait_start == TMO) begin
          m_active = 0; m_busy = 0; err_set = 1;
        end
      end else begin
        if (cyc - m_rdy_at == G) m_sws = m_tgt;
        if (cyc - m_rdy_at == 2 * G) begin
          m_gate = 1; m_busy = 0; m_active = 0;
        end
      end
      if (err_set) m_err = 1;
      else if (t_clr) m_err = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("sws", 32'(d_sws), 32'(m_sws));
    chk("sel_onehot", 32'(d_sel), 32'(1) << m_sws);
    chk("clk_gate_en", 32'(d_gate), 32'(m_gate));
    chk("sw_busy", 32'(d_busy), 32'(m_busy));
    chk("sw_err", 32'(d_err), 32'(m_err));
    if (!m_rst_edge && d_sel !== p_sel) chk("sel_change_gated", 32'(d_gate), 32'd0);
    p_sel = d_sel;
  endtask

  task automatic run_until_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (!d_busy) break;
    end
    chk("settle_idle", 32'(d_busy), 32'd0);
  endtask

  initial begin
    rst = 1; t_sw = 2'd3; t_rdy = 4'b1001; t_css = 0; t_stop = 0; t_wuck = 0; t_clr = 0;
    p_sel = 4'b0001;
    m_sws = 0; m_gate = 1; m_busy = 0; m_err = 0; m_active = 0; m_tgt = 0;
    m_wait_start = 0; m_rdy_at = -1; m_rst_edge = 1;

    // Reset held with a pending software request
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_sws", 32'(d_sws), 32'd0);
      chk("t1_sel", 32'(d_sel), 32'b0001);
      chk("t1_gate", 32'(d_gate), 32'd1);
      chk("t1_busy", 32'(d_busy), 32'd0);
    end

    // HSI -> PLL1 with ready already present
    rst = 0; t_sw = 2'd0;
    step();
    t_sw = 2'd3;
    step(); chk("t2_e0_busy", 32'(d_busy), 32'd1); chk("t2_e0_gate", 32'(d_gate), 32'd1);
    step(); chk("t2_e1_gate", 32'(d_gate), 32'd0);
    step(); chk("t2_e2_sws", 32'(d_sws), 32'd0);
    step(); chk("t2_e3_sws", 32'(d_sws), 32'd3); chk("t2_e3_sel", 32'(d_sel), 32'b1000);
    step(); chk("t2_e4_gate", 32'(d_gate), 32'd0);
    step(); chk("t2_e5_gate", 32'(d_gate), 32'd1); chk("t2_e5_busy", 32'(d_busy), 32'd0);

    // Back to HSI, then time out waiting for HSE
    t_sw = 2'd0;
    run_until_idle(20);
    t_sw = 2'd2; t_rdy = 4'b1011;
    step(); chk("t3_start", 32'(d_busy), 32'd1);
    for (int i = 0; i < TMO - 1; i++) begin
      step(); chk("t3_no_gate", 32'(d_gate), 32'd1);
    end
    step();
    chk("t3_err", 32'(d_err), 32'd1); chk("t3_busy", 32'(d_busy), 32'd0);
    chk("t3_sws", 32'(d_sws), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(); chk("t3_no_retry", 32'(d_busy), 32'd0);
    end
    t_clr = 1;
    step(); chk("t3_clr", 32'(d_err), 32'd0); chk("t3_clr_busy", 32'(d_busy), 32'd0);
    t_clr = 0;
    step(); chk("t3_retry", 32'(d_busy), 32'd1);
    t_rdy = 4'b1111;
    run_until_idle(30);
    chk("t3_hse", 32'(d_sws), 32'd2);

    // HSE clock security failure forces HSI, then aborts a new HSE attempt
    t_css = 1;
    step(); chk("t4_forced", 32'(d_busy), 32'd1);
    run_until_idle(20);
    chk("t4_sws", 32'(d_sws), 32'd0); chk("t4_sel", 32'(d_sel), 32'b0001);
    step(); chk("t4_try_hse", 32'(d_busy), 32'd1);
    step(); chk("t4_abort_err", 32'(d_err), 32'd1); chk("t4_abort_busy", 32'(d_busy), 32'd0);
    chk("t4_abort_gate", 32'(d_gate), 32'd1);
    t_css = 0; t_clr = 1; t_sw = 2'd3;
    step();
    t_clr = 0;

    // Stop entry forces the wake-up clock and holds it
    run_until_idle(30);
    chk("t5_pll", 32'(d_sws), 32'd3);
    t_stop = 1; t_wuck = 1; t_rdy = 4'b1011;
    run_until_idle(30);
    chk("t5_csi", 32'(d_sws), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); chk("t5_hold", 32'(d_sws), 32'd1);
    end

    // Reset while gated aborts the sequence
    t_stop = 0; t_sw = 2'd3; t_rdy = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step();
      if (d_gate === 1'b0) break;
    end
    chk("t6_gated", 32'(d_gate), 32'd0);
    rst = 1;
    step();
    chk("t6_gate", 32'(d_gate), 32'd1); chk("t6_sws", 32'(d_sws), 32'd0);
    chk("t6_busy", 32'(d_busy), 32'd0);
    rst = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) t_sw = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 15) == 0) t_rdy[b] = ~t_rdy[b];
      if ($urandom_range(0, 24) == 0) t_css = ~t_css;
      if ($urandom_range(0, 39) == 0) begin
        t_stop = ~t_stop;
        t_wuck = 1'($urandom_range(0, 1));
      end
      t_clr = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
